axi4_lite_master_basic: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple command/response handshake into AXI4-Lite read and write transactions. It is the initiator counterpart of the register-bank slave. Control FSMs and test harnesses use it to program and poll register banks over the AXI4-Lite interconnect.

---
 rtl/axi4_lite_pkg.sv | 20 ++
 rtl/axi4_lite_master_basic.sv | 168 ++++++++++++++++
 tb/tb_axi4_lite_master_basic.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master sequencing states.
package axi4_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RESPOND      = 3'd5
    } axi4_lite_master_state_t;

endpackage

// File: rtl/axi4_lite_master_basic.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response back.
// state           | meaning
// ST_IDLE         | req_ready high, waiting for a command
// ST_WR_ADDR_DATA | AW and W offered together, each retired independently
// ST_WR_RESP      | bready high, waiting for the B beat
// ST_RD_ADDR      | arvalid high, waiting for arready
// ST_RD_DATA      | rready high, waiting for the R beat
// ST_RESPOND      | resp_valid high with captured result until resp_ready
module axi4_lite_master_basic
    import axi4_lite_pkg::*;
#(
    parameter int addr_width = 7
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [addr_width-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_code,
    output logic                  resp_error,

    output logic [addr_width-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [addr_width-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    axi4_lite_master_state_t state;

    logic [addr_width-1:0] addr_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_fire;
    logic                  w_fire;

    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid && m_axi_wready;

    // A single address register serves both channels; only one is ever active.
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = AXI_PROT_DEFAULT;
    assign m_axi_arprot = AXI_PROT_DEFAULT;
    assign resp_error   = resp_code[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_write    <= 1'b0;
            resp_rdata    <= 32'h0;
            resp_code     <= AXI_RESP_OKAY;
            addr_q        <= '0;
            m_axi_wdata   <= 32'h0;
            m_axi_wstrb   <= 4'h0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        addr_q      <= req_addr;
                        m_axi_wdata <= req_wdata;
                        m_axi_wstrb <= req_wstrb;
                        resp_write  <= req_write;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        if (req_write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WR_ADDR_DATA;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    // Either channel may retire first, or both on the same edge.
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        resp_rdata   <= 32'h0;
                        resp_code    <= m_axi_bresp;
                        resp_valid   <= 1'b1;
                        state        <= ST_RESPOND;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        resp_rdata   <= m_axi_rdata;
                        resp_code    <= m_axi_rresp;
                        resp_valid   <= 1'b1;
                        state        <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_basic.sv
// Bench for axi4_lite_master_basic: behavioural register-bank slave plus a word-array reference model.
module tb_axi4_lite_master_basic;
    import axi4_lite_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_write, resp_error;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_code;
    logic [6:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0, m_axi_bready;
    logic        m_axi_arvalid, m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0, m_axi_rready;

    axi4_lite_master_basic #(.addr_width(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .resp_code(resp_code), .resp_error(resp_error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model (acts on falling edges) ----------------
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit         force_en = 1'b0;
    logic [1:0] force_code = 2'b00;
    logic [31:0] smem [32] = '{default: 32'h0};
    int  aw_hold = 0, w_hold = 0, ar_hold = 0, b_hold = 0, r_hold = 0;
    bit  aw_fire = 0, w_fire = 0, ar_fire = 0, b_fire = 0, r_fire = 0;
    bit  aw_stall = 0, w_stall = 0, ar_stall = 0;
    bit  aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [6:0]  cap_awaddr = '0, cap_araddr = '0, wr_addr = '0;
    logic [31:0] cap_wdata = '0, wr_data = '0;
    logic [3:0]  cap_wstrb = '0, wr_strb = '0;
    int b_beats = 0, r_beats = 0;

    function automatic bit is_err(input logic [6:0] a);
        return a >= 7'h60;
    endfunction

    function automatic logic [1:0] resp_for(input logic [6:0] a);
        if (force_en) return force_code;
        return is_err(a) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            aw_hold = 0; w_hold = 0; ar_hold = 0; b_hold = 0; r_hold = 0;
            aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
            aw_stall = 0; w_stall = 0; ar_stall = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
        end else begin
            // A VALID left unanswered at the last edge must still be there, unchanged.
            if (aw_stall) begin
                check("aw_valid_held", m_axi_awvalid, 1);
                check("aw_addr_stable", m_axi_awaddr, cap_awaddr);
            end
            if (w_stall) begin
                check("w_valid_held", m_axi_wvalid, 1);
                check("w_data_stable", {m_axi_wstrb, m_axi_wdata}, {cap_wstrb, cap_wdata});
            end
            if (ar_stall) begin
                check("ar_valid_held", m_axi_arvalid, 1);
                check("ar_addr_stable", m_axi_araddr, cap_araddr);
            end
            if (b_fire) begin b_pend = 0; b_beats++; end
            if (r_fire) begin r_pend = 0; r_beats++; end
            if (aw_fire) begin aw_got = 1; wr_addr = cap_awaddr; aw_hold = 0; end
            if (w_fire) begin w_got = 1; wr_data = cap_wdata; wr_strb = cap_wstrb; w_hold = 0; end
            if (aw_got && w_got) begin
                if (!is_err(wr_addr))
                    for (int i = 0; i < 4; i++)
                        if (wr_strb[i]) smem[wr_addr[6:2]][8*i +: 8] = wr_data[8*i +: 8];
                m_axi_bresp = resp_for(wr_addr);
                aw_got = 0; w_got = 0; b_pend = 1; b_hold = 0;
            end
            if (ar_fire) begin
                m_axi_rdata = is_err(cap_araddr) ? (32'hBAD0_0000 | 32'(cap_araddr))
                                                 : smem[cap_araddr[6:2]];
                m_axi_rresp = resp_for(cap_araddr);
                r_pend = 1; r_hold = 0; ar_hold = 0;
            end
            if (m_axi_awvalid) cap_awaddr = m_axi_awaddr;
            if (m_axi_wvalid) begin cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; end
            if (m_axi_arvalid) cap_araddr = m_axi_araddr;
            m_axi_awready = 0;
            if (m_axi_awvalid && !aw_got) begin
                if (aw_hold < aw_wait) aw_hold++; else m_axi_awready = 1;
            end
            m_axi_wready = 0;
            if (m_axi_wvalid && !w_got) begin
                if (w_hold < w_wait) w_hold++; else m_axi_wready = 1;
            end
            m_axi_arready = 0;
            if (m_axi_arvalid) begin
                if (ar_hold < ar_wait) ar_hold++; else m_axi_arready = 1;
            end
            m_axi_bvalid = 0;
            if (b_pend) begin
                if (b_hold < b_wait) b_hold++; else m_axi_bvalid = 1;
            end
            m_axi_rvalid = 0;
            if (r_pend) begin
                if (r_hold < r_wait) r_hold++; else m_axi_rvalid = 1;
            end
            aw_fire  = m_axi_awvalid && m_axi_awready;
            w_fire   = m_axi_wvalid && m_axi_wready;
            ar_fire  = m_axi_arvalid && m_axi_arready;
            b_fire   = m_axi_bvalid && m_axi_bready;
            r_fire   = m_axi_rvalid && m_axi_rready;
            aw_stall = m_axi_awvalid && !m_axi_awready;
            w_stall  = m_axi_wvalid && !m_axi_wready;
            ar_stall = m_axi_arvalid && !m_axi_arready;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] model [32] = '{default: 32'h0};

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        logic [1:0]  code;
    } exp_t;

    task automatic expect_for(input bit wr, input logic [6:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] e_rdata,
                              output logic [1:0] e_code);
        bit bad;
        bad = (a >= 7'h60);
        e_code = force_en ? force_code : (bad ? 2'b10 : 2'b00);
        if (wr) begin
            e_rdata = 32'h0;
            if (!bad)
                for (int i = 0; i < 4; i++)
                    if (s[i]) model[a >> 2][8*i +: 8] = d[8*i +: 8];
        end else begin
            e_rdata = bad ? (32'hBAD0_0000 + {25'h0, a}) : model[a >> 2];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_waits(input int aw, input int w, input int b, input int ar, input int r);
        aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_axi_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
        check({tag, "_axi_readies"}, {m_axi_bready, m_axi_rready}, 2'b00);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_fields"}, {resp_write, resp_error, resp_code, resp_rdata}, 36'h0);
        check({tag, "_addr_data"}, {m_axi_awaddr, m_axi_araddr, m_axi_wstrb, m_axi_wdata}, 50'h0);
    endtask

    task automatic run_txn(input bit wr, input logic [6:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int hold, input string tag,
                           output int lat, output int aw_cyc, output int w_cyc);
        logic [31:0] e_rdata;
        logic [1:0]  e_code;
        int guard, b0, r0;
        expect_for(wr, a, d, s, e_rdata, e_code);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        guard = 0;
        while (!req_ready && guard < 50) begin tick(); guard++; end
        check({tag, "_req_ready"}, req_ready, 1);
        b0 = b_beats; r0 = r_beats;
        tick();
        req_valid = 0;
        req_addr = 7'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
        check({tag, "_req_ready_drop"}, req_ready, 0);
        lat = 0; aw_cyc = 0; w_cyc = 0;
        while (!resp_valid && lat < 200) begin
            aw_cyc += int'(m_axi_awvalid);
            w_cyc += int'(m_axi_wvalid);
            tick();
            lat++;
        end
        check({tag, "_resp_valid"}, resp_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, resp_valid, 1);
            check({tag, "_hold_rdata"}, resp_rdata, e_rdata);
            check({tag, "_hold_req_ready"}, req_ready, 0);
            check({tag, "_hold_no_axi"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
            tick();
        end
        check({tag, "_resp_write"}, resp_write, wr);
        check({tag, "_resp_rdata"}, resp_rdata, e_rdata);
        check({tag, "_resp_code"}, resp_code, e_code);
        check({tag, "_resp_error"}, resp_error, e_code[1]);
        resp_ready = 1;
        tick();
        resp_ready = 0;
        check({tag, "_resp_done"}, resp_valid, 0);
        check({tag, "_req_ready_back"}, req_ready, 1);
        if (wr) check({tag, "_b_beats"}, b_beats - b0, 1);
        else    check({tag, "_r_beats"}, r_beats - r0, 1);
    endtask

    initial begin
        int lat, awc, wc, guard, n_acc, n_resp;
        logic [31:0] e_rdata;
        logic [1:0]  e_code;
        exp_t q[$];
        exp_t e;

        // reset
        rst = 1;
        repeat (3) tick();
        check_idle_outputs("reset_held");
        check("prot", {m_axi_awprot, m_axi_arprot}, 6'h0);
        rst = 0;
        tick();
        check_idle_outputs("reset_released");

        // write then read back against a zero-wait slave
        set_waits(0, 0, 0, 0, 0);
        run_txn(1, 7'h04, 32'h1234_5678, 4'hF, 0, "wr04", lat, awc, wc);
        check("wr04_latency", lat, 2);
        run_txn(0, 7'h04, 32'h0, 4'h0, 0, "rd04", lat, awc, wc);
        check("rd04_latency", lat, 2);

        // AW stalled three cycles, W immediate
        set_waits(3, 0, 0, 0, 0);
        run_txn(1, 7'h08, 32'hA5A5_0F0F, 4'h5, 0, "aw_stall", lat, awc, wc);
        check("aw_stall_aw_cycles", awc, 4);
        check("aw_stall_w_cycles", wc, 1);

        // slave error on a slow read
        set_waits(0, 0, 0, 0, 5);
        force_en = 1; force_code = AXI_RESP_SLVERR;
        run_txn(0, 7'h04, 32'h0, 4'h0, 0, "rd_slverr", lat, awc, wc);
        check("rd_slverr_latency", lat, 7);
        force_en = 0;

        // response back-pressure
        set_waits(0, 0, 0, 0, 0);
        run_txn(0, 7'h08, 32'h0, 4'h0, 10, "resp_hold", lat, awc, wc);

        // reset while waiting for B
        set_waits(0, 0, 20, 0, 0);
        expect_for(1, 7'h10, 32'hCAFE_F00D, 4'hF, e_rdata, e_code);
        req_valid = 1; req_write = 1; req_addr = 7'h10; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
        tick();
        req_valid = 0;
        guard = 0;
        while (!m_axi_bready && guard < 20) begin tick(); guard++; end
        check("rst_reach_wresp", m_axi_bready, 1);
        rst = 1;
        tick();
        check_idle_outputs("mid_reset");
        rst = 0;
        set_waits(0, 0, 0, 0, 0);
        run_txn(0, 7'h10, 32'h0, 4'h0, 0, "after_rst", lat, awc, wc);

        // back-to-back against a zero-wait slave
        n_acc = 0; n_resp = 0;
        req_valid = 1; resp_ready = 1;
        req_write = 1'($urandom); req_addr = 7'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) begin
                n_resp++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("b2b_write", resp_write, e.wr);
                    check("b2b_rdata", resp_rdata, e.rdata);
                    check("b2b_code", resp_code, e.code);
                end
            end
            if (req_ready) begin
                expect_for(req_write, req_addr, req_wdata, req_wstrb, e.rdata, e.code);
                e.wr = req_write;
                q.push_back(e);
                n_acc++;
                tick();
                req_write = 1'($urandom); req_addr = 7'($urandom);
                req_wdata = $urandom; req_wstrb = 4'($urandom);
            end else begin
                tick();
            end
        end
        req_valid = 0; resp_ready = 0;
        check("b2b_accepts", n_acc, 10);
        check("b2b_responses", n_resp, 10);
        check("b2b_queue_empty", q.size(), 0);

        // randomized traffic with random slave wait states
        for (int t = 0; t < 24; t++) begin
            set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            run_txn(1'($urandom), 7'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 2), "rand", lat, awc, wc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
